dm_port_arbiter: RTL and testbench

//  Shares the single-port synchronous Data_Mem between two requesters:
//  - the CPU load/store path;
//  - a loader/debug port that preloads or inspects data memory while the CPU runs.

---
 rtl/dm_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_dm_port_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Single-port Data_Mem arbiter between the CPU load/store path and a loader/debug port.
// One access per cycle; a registered owner tag routes the returning read data.
module dm_port_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              dm_we,
    output logic              dm_re,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    localparam logic [0:0] C_IDLE   = 1'b0;
    localparam logic [0:0] C_RDWAIT = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_LD   = 2'b10;

    logic [0:0]       cpu_fsm_q, cpu_fsm_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]       own_q, own_d;
    logic             ld_win_s;
    logic             cpu_win_s;

    // Arbitration: the loader wins when starved, when the CPU is quiet, or while the CPU waits for read data
    always_comb begin
        ld_win_s  = 1'b0;
        cpu_win_s = 1'b0;
        if (RST) begin
            ld_win_s  = 1'b0;
            cpu_win_s = 1'b0;
        end else begin
            ld_win_s  = ld_req && ((wait_cnt_q == CNT_MAX) || !cpu_req || (cpu_fsm_q == C_RDWAIT));
            cpu_win_s = !ld_win_s && cpu_req && (cpu_fsm_q == C_IDLE);
        end
    end

    // Data_Mem command mux driven by the winner
    always_comb begin
        dm_we    = 1'b0;
        dm_re    = 1'b0;
        dm_addr  = {ADDR_W{1'b0}};
        dm_wdata = {DATA_W{1'b0}};
        if (ld_win_s) begin
            dm_we    = ld_we;
            dm_re    = !ld_we;
            dm_addr  = ld_addr;
            dm_wdata = ld_wdata;
        end else if (cpu_win_s) begin
            dm_we    = cpu_we;
            dm_re    = !cpu_we;
            dm_addr  = cpu_addr;
            dm_wdata = cpu_wdata;
        end else begin
            dm_we    = 1'b0;
            dm_re    = 1'b0;
        end
    end

    // Requester-facing outputs; reset suppresses any read still in flight
    always_comb begin
        ld_gnt     = ld_win_s;
        cpu_rvalid = !RST && (own_q == OWN_CPU);
        ld_rvalid  = !RST && (own_q == OWN_LD);
        cpu_rdata  = cpu_rvalid ? dm_rdata : {DATA_W{1'b0}};
        ld_rdata   = ld_rvalid ? dm_rdata : {DATA_W{1'b0}};
        case (cpu_fsm_q)
            C_IDLE:   cpu_stall = !RST && cpu_req && !(cpu_win_s && cpu_we);
            C_RDWAIT: cpu_stall = 1'b0;
            default:  cpu_stall = 1'b0;
        endcase
    end

    // Next-state: CPU FSM, loader starvation counter, read owner tag
    always_comb begin
        cpu_fsm_d  = cpu_fsm_q;
        wait_cnt_d = wait_cnt_q;
        own_d      = OWN_NONE;
        case (cpu_fsm_q)
            C_IDLE: begin
                if (cpu_win_s && !cpu_we) begin
                    cpu_fsm_d = C_RDWAIT;
                end else begin
                    cpu_fsm_d = C_IDLE;
                end
            end
            C_RDWAIT: cpu_fsm_d = C_IDLE;
            default:  cpu_fsm_d = C_IDLE;
        endcase
        if (!ld_req || ld_win_s) begin
            wait_cnt_d = {CNT_W{1'b0}};
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        if (cpu_win_s && !cpu_we) begin
            own_d = OWN_CPU;
        end else if (ld_win_s && !ld_we) begin
            own_d = OWN_LD;
        end else begin
            own_d = OWN_NONE;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            cpu_fsm_q  <= C_IDLE;
            wait_cnt_q <= {CNT_W{1'b0}};
            own_q      <= OWN_NONE;
        end else begin
            cpu_fsm_q  <= cpu_fsm_d;
            wait_cnt_q <= wait_cnt_d;
            own_q      <= own_d;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural single-port Data_Mem.
module tb_dm_port_arbiter;

    logic        CLK;
    logic        RST;
    logic        cpu_req, cpu_we;
    logic [6:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        ld_req, ld_we;
    logic [6:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic [31:0] ld_rdata;
    logic        ld_rvalid;
    logic        dm_we, dm_re;
    logic [6:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [0:127];
    logic [5:0]  ctl;
    int          n_checks;
    int          n_pass;

    dm_port_arbiter #(.ADDR_W(7), .DATA_W(32), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .dm_we(dm_we), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    // Control outputs packed as {stall, gnt, dm_we, dm_re, cpu_rvalid, ld_rvalid}
    assign ctl = {cpu_stall, ld_gnt, dm_we, dm_re, cpu_rvalid, ld_rvalid};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous Data_Mem: write-then-read in the next cycle sees the new data
    always @(posedge CLK) begin
        if (dm_we) mem[dm_addr] <= dm_wdata;
        if (dm_re) dm_rdata <= mem[dm_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst,
                        input logic cr, input logic cwe, input logic [6:0] ca, input logic [31:0] cwd,
                        input logic lr, input logic lwe, input logic [6:0] la, input logic [31:0] lwd);
        @(negedge CLK);
        RST = rst;
        cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
        ld_req = lr;  ld_we = lwe;  ld_addr = la;  ld_wdata = lwd;
        #1;
    endtask

    initial begin
        logic [6:0] ca;
        n_checks = 0;
        n_pass   = 0;
        RST = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 7'd0; cpu_wdata = 32'd0;
        ld_req = 1'b0;  ld_we = 1'b0;  ld_addr = 7'd0;  ld_wdata = 32'd0;

        // Reset with both requesting
        step(1'b1, 1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 1'b1, 1'b1, 7'h10, 32'h0000AAAA);
        check("rst_ctl", {26'd0, ctl}, 32'd0);
        check("rst_addr", {25'd0, dm_addr}, 32'd0);
        check("rst_wdata", dm_wdata, 32'd0);

        // First cycle after reset: CPU store wins
        step(1'b0, 1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 1'b1, 1'b1, 7'h10, 32'h0000AAAA);
        check("st_ctl", {26'd0, ctl}, {26'd0, 6'b001000});
        check("st_addr", {25'd0, dm_addr}, 32'd5);
        check("st_wdata", dm_wdata, 32'hDEADBEEF);

        // CPU load addr 5: issue, then return while the loader write takes the free slot
        step(1'b0, 1'b1, 1'b0, 7'd5, 32'd0, 1'b1, 1'b1, 7'h10, 32'h0000AAAA);
        check("ld5_issue_ctl", {26'd0, ctl}, {26'd0, 6'b100100});
        check("ld5_issue_addr", {25'd0, dm_addr}, 32'd5);
        step(1'b0, 1'b1, 1'b0, 7'd5, 32'd0, 1'b1, 1'b1, 7'h10, 32'h0000AAAA);
        check("ld5_ret_ctl", {26'd0, ctl}, {26'd0, 6'b011010});
        check("ld5_ret_data", cpu_rdata, 32'hDEADBEEF);
        check("ld5_ret_addr", {25'd0, dm_addr}, 32'h10);

        // Loader write 0x7F then CPU load 0x7F
        step(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b1, 7'h7F, 32'h12345678);
        check("lw7f_ctl", {26'd0, ctl}, {26'd0, 6'b011000});
        check("lw7f_addr", {25'd0, dm_addr}, 32'h7F);
        step(1'b0, 1'b1, 1'b0, 7'h7F, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        check("cr7f_issue_ctl", {26'd0, ctl}, {26'd0, 6'b100100});
        step(1'b0, 1'b1, 1'b0, 7'h7F, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        check("cr7f_ret_ctl", {26'd0, ctl}, {26'd0, 6'b000010});
        check("cr7f_ret_data", cpu_rdata, 32'h12345678);

        // CPU load with loader read pending: loader slips into the C_RDWAIT slot
        step(1'b0, 1'b1, 1'b0, 7'd5, 32'd0, 1'b1, 1'b0, 7'h10, 32'd0);
        check("ovl_n_ctl", {26'd0, ctl}, {26'd0, 6'b100100});
        step(1'b0, 1'b1, 1'b0, 7'd5, 32'd0, 1'b1, 1'b0, 7'h10, 32'd0);
        check("ovl_n1_ctl", {26'd0, ctl}, {26'd0, 6'b010110});
        check("ovl_n1_cdata", cpu_rdata, 32'hDEADBEEF);
        check("ovl_n1_addr", {25'd0, dm_addr}, 32'h10);
        step(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        check("ovl_n2_ctl", {26'd0, ctl}, {26'd0, 6'b000001});
        check("ovl_n2_ldata", ld_rdata, 32'h0000AAAA);

        // Back-to-back CPU stores against a held loader write: forced grant on the fifth cycle
        for (int i = 0; i < 6; i++) begin
            ca = (i < 4) ? 7'(32'h20 + i) : 7'h24;
            step(1'b0, 1'b1, 1'b1, ca, {25'd0, ca}, 1'b1, 1'b1, (i < 5) ? 7'h30 : 7'h31, 32'h55);
            check($sformatf("starve_gnt%0d", i), {31'd0, ld_gnt}, {31'd0, i == 4});
            check($sformatf("starve_stall%0d", i), {31'd0, cpu_stall}, {31'd0, i == 4});
            check($sformatf("starve_addr%0d", i), {25'd0, dm_addr}, (i == 4) ? 32'h30 : {25'd0, ca});
        end
        step(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);

        // Read back the forced loader write and the delayed CPU store
        step(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'h30, 32'd0);
        check("rb_ld_gnt", {26'd0, ctl}, {26'd0, 6'b010100});
        step(1'b0, 1'b1, 1'b0, 7'h24, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        check("rb_ld_ret_ctl", {26'd0, ctl}, {26'd0, 6'b100101});
        check("rb_ld_ret_data", ld_rdata, 32'h55);
        step(1'b0, 1'b1, 1'b0, 7'h24, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        check("rb_cpu_ret_ctl", {26'd0, ctl}, {26'd0, 6'b000010});
        check("rb_cpu_ret_data", cpu_rdata, 32'h24);

        // Reset the cycle after a loader read grant
        step(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'h7F, 32'd0);
        check("rr_gnt_ctl", {26'd0, ctl}, {26'd0, 6'b010100});
        step(1'b1, 1'b1, 1'b1, 7'd3, 32'd9, 1'b1, 1'b1, 7'd4, 32'd7);
        check("rr_rst_ctl", {26'd0, ctl}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
        check("rr_post_ctl", {26'd0, ctl}, 32'd0);
        check("rr_wait_cnt", {29'd0, dut.wait_cnt_q}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
